// File: rtl/na_conf_pkg.sv
// Configuration register map shared by the network-adapter conf reader and responder.
package na_conf_pkg;

  localparam logic [7:0] REG_TILEID          = 8'h00;
  localparam logic [7:0] REG_NUMTILES        = 8'h01;
  localparam logic [7:0] REG_CONF            = 8'h03;
  localparam logic [7:0] REG_COREBASE        = 8'h04;
  localparam logic [7:0] REG_DOMAIN_NUMCORES = 8'h06;
  localparam logic [7:0] REG_GMEM_SIZE       = 8'h07;
  localparam logic [7:0] REG_GMEM_TILE       = 8'h08;
  localparam logic [7:0] REG_LMEM_SIZE       = 8'h09;
  localparam logic [7:0] REG_NUMCTS          = 8'h0A;
  localparam logic [7:0] REG_SEED            = 8'h0B;
  localparam logic [7:0] REG_CDC             = 8'h40;
  localparam logic [7:0] REG_CDC_DYN         = 8'h41;
  localparam logic [7:0] REG_CDC_CONF        = 8'h42;
  localparam logic [7:0] REG_CTLIST          = 8'h80;

  localparam int CONF_MPSIMPLE_BIT = 0;
  localparam int CONF_DMA_BIT      = 1;

  localparam int          CTLIST_ENTRY_W = 16;
  localparam logic [3:0]  LAST_FIXED     = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_FIXED,
    ST_RD_CTLIST,
    ST_WR_CDC
  } conf_state_e;

  // Word index read at each position of the fixed part of a scan.
  function automatic logic [7:0] fixed_word(input logic [3:0] pos);
    logic [7:0] w;
    case (pos)
      4'd0:    w = REG_TILEID;
      4'd1:    w = REG_NUMTILES;
      4'd2:    w = REG_CONF;
      4'd3:    w = REG_COREBASE;
      4'd4:    w = REG_DOMAIN_NUMCORES;
      4'd5:    w = REG_GMEM_SIZE;
      4'd6:    w = REG_GMEM_TILE;
      4'd7:    w = REG_LMEM_SIZE;
      4'd8:    w = REG_NUMCTS;
      4'd9:    w = REG_SEED;
      4'd10:   w = REG_CDC;
      4'd11:   w = REG_CDC_DYN;
      default: w = REG_TILEID;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] word_addr(input logic [7:0] w);
    return {6'd0, w, 2'b00};
  endfunction

endpackage

// File: rtl/na_conf_ctlist_store.sv
// Compute-tile-list cache: one write port, synchronous clear-all, asynchronous read.
module na_conf_ctlist_store
  import na_conf_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                      clk,
  input  logic                      clr_i,
  input  logic                      we_i,
  input  logic [AW-1:0]             waddr_i,
  input  logic [CTLIST_ENTRY_W-1:0] wdata_i,
  input  logic [AW-1:0]             raddr_i,
  output logic [CTLIST_ENTRY_W-1:0] rdata_o
);

  logic [CTLIST_ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/networkadapter_conf_reader.sv
// Scans the network-adapter configuration register map into local registers
// and issues single CDC-configuration writes on request.
module networkadapter_conf_reader
  import na_conf_pkg::*;
#(
  parameter  int DW      = 32,
  parameter  int RD_WAIT = 0,
  parameter  int MAX_CTS = 64,
  localparam int IW      = $clog2(MAX_CTS),
  localparam int NW      = $clog2(MAX_CTS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  input  logic                      cdc_wr_req_i,
  input  logic [2:0]                cdc_wr_data_i,
  output logic                      cdc_wr_ack_o,
  output logic [15:0]               conf_addr_o,
  output logic [DW-1:0]             conf_din_o,
  output logic                      conf_en_o,
  output logic                      conf_we_o,
  input  logic [DW-1:0]             conf_dout_i,
  output logic [DW-1:0]             tile_id_o,
  output logic [DW-1:0]             num_tiles_o,
  output logic [DW-1:0]             core_base_o,
  output logic [DW-1:0]             domain_numcores_o,
  output logic [DW-1:0]             gmem_size_o,
  output logic [DW-1:0]             gmem_tile_o,
  output logic [DW-1:0]             lmem_size_o,
  output logic [DW-1:0]             seed_o,
  output logic [NW-1:0]             num_cts_o,
  output logic                      na_mpsimple_o,
  output logic                      na_dma_o,
  output logic                      cdc_present_o,
  output logic                      cdc_dynamic_o,
  input  logic [IW-1:0]             ctlist_idx_i,
  output logic [CTLIST_ENTRY_W-1:0] ctlist_tile_o
);

  localparam int             WW        = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
  localparam logic [WW-1:0]  WAIT_LAST = WW'(RD_WAIT);

  conf_state_e          state_q;
  logic [3:0]           fix_q;
  logic [IW-1:0]        k_q;
  logic [WW-1:0]        wait_q;
  logic                 busy_q, done_q, ack_q, en_q, we_q;
  logic [15:0]          addr_q;
  logic [DW-1:0]        din_q;
  logic [DW-1:0]        tile_id_q, num_tiles_q, core_base_q, domain_numcores_q;
  logic [DW-1:0]        gmem_size_q, gmem_tile_q, lmem_size_q, seed_q;
  logic [NW-1:0]        num_cts_q;
  logic                 mpsimple_q, dma_q, cdc_present_q, cdc_dynamic_q;

  logic                      sample;
  logic                      last_entry;
  logic [IW-1:0]             k_d;
  logic [NW-1:0]             num_cts_d;
  logic                      st_clr, st_we;
  logic [CTLIST_ENTRY_W-1:0] st_wdata, st_rdata;

  always_comb begin
    sample     = (wait_q == WAIT_LAST);
    k_d        = k_q + IW'(1);
    last_entry = ((NW'(k_q) + NW'(1)) == num_cts_q);
    num_cts_d  = (conf_dout_i > DW'(MAX_CTS)) ? NW'(MAX_CTS) : conf_dout_i[NW-1:0];
    st_clr     = rst || ((state_q == ST_IDLE) && start_i);
    st_we      = (state_q == ST_RD_CTLIST) && sample;
    // Two 16-bit entries per word, even entry in the upper half.
    st_wdata   = k_q[0] ? conf_dout_i[15:0] : conf_dout_i[31:16];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      fix_q             <= 4'd0;
      k_q               <= '0;
      wait_q            <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      ack_q             <= 1'b0;
      en_q              <= 1'b0;
      we_q              <= 1'b0;
      addr_q            <= 16'h0000;
      din_q             <= '0;
      tile_id_q         <= '0;
      num_tiles_q       <= '0;
      core_base_q       <= '0;
      domain_numcores_q <= '0;
      gmem_size_q       <= '0;
      gmem_tile_q       <= '0;
      lmem_size_q       <= '0;
      seed_q            <= '0;
      num_cts_q         <= '0;
      mpsimple_q        <= 1'b0;
      dma_q             <= 1'b0;
      cdc_present_q     <= 1'b0;
      cdc_dynamic_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            fix_q   <= 4'd0;
            wait_q  <= '0;
            en_q    <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= word_addr(fixed_word(4'd0));
            state_q <= ST_RD_FIXED;
          end else if (cdc_wr_req_i) begin
            busy_q  <= 1'b1;
            ack_q   <= 1'b1;
            en_q    <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= word_addr(REG_CDC_CONF);
            din_q   <= DW'(cdc_wr_data_i);
            state_q <= ST_WR_CDC;
          end else begin
            en_q <= 1'b0;
            we_q <= 1'b0;
          end
        end
        ST_RD_FIXED: begin
          if (!sample) begin
            wait_q <= wait_q + WW'(1);
          end else begin
            wait_q <= '0;
            case (fix_q)
              4'd0:  tile_id_q         <= conf_dout_i;
              4'd1:  num_tiles_q       <= conf_dout_i;
              4'd2: begin
                mpsimple_q <= conf_dout_i[CONF_MPSIMPLE_BIT];
                dma_q      <= conf_dout_i[CONF_DMA_BIT];
              end
              4'd3:  core_base_q       <= conf_dout_i;
              4'd4:  domain_numcores_q <= conf_dout_i;
              4'd5:  gmem_size_q       <= conf_dout_i;
              4'd6:  gmem_tile_q       <= conf_dout_i;
              4'd7:  lmem_size_q       <= conf_dout_i;
              4'd8:  num_cts_q         <= num_cts_d;
              4'd9:  seed_q            <= conf_dout_i;
              4'd10: cdc_present_q     <= conf_dout_i[0];
              4'd11: cdc_dynamic_q     <= conf_dout_i[0];
              default: tile_id_q       <= tile_id_q;
            endcase
            // num_cts was captured at position 8, so it is valid here.
            if (fix_q == LAST_FIXED) begin
              if (num_cts_q == NW'(0)) begin
                state_q <= ST_IDLE;
                en_q    <= 1'b0;
                addr_q  <= 16'h0000;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                k_q     <= '0;
                addr_q  <= word_addr(REG_CTLIST);
                state_q <= ST_RD_CTLIST;
              end
            end else begin
              fix_q  <= fix_q + 4'd1;
              addr_q <= word_addr(fixed_word(fix_q + 4'd1));
            end
          end
        end
        ST_RD_CTLIST: begin
          if (!sample) begin
            wait_q <= wait_q + WW'(1);
          end else begin
            wait_q <= '0;
            if (last_entry) begin
              state_q <= ST_IDLE;
              en_q    <= 1'b0;
              addr_q  <= 16'h0000;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              k_q    <= k_d;
              addr_q <= word_addr(REG_CTLIST) + 16'({k_d, 1'b0});
            end
          end
        end
        ST_WR_CDC: begin
          state_q <= ST_IDLE;
          en_q    <= 1'b0;
          we_q    <= 1'b0;
          addr_q  <= 16'h0000;
          din_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          en_q    <= 1'b0;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  na_conf_ctlist_store #(
    .DEPTH (MAX_CTS),
    .AW    (IW)
  ) u_store (
    .clk     (clk),
    .clr_i   (st_clr),
    .we_i    (st_we),
    .waddr_i (k_q),
    .wdata_i (st_wdata),
    .raddr_i (ctlist_idx_i),
    .rdata_o (st_rdata)
  );

  assign ctlist_tile_o     = (NW'(ctlist_idx_i) < num_cts_q) ? st_rdata : 16'h0000;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign cdc_wr_ack_o      = ack_q;
  assign conf_addr_o       = addr_q;
  assign conf_din_o        = din_q;
  assign conf_en_o         = en_q;
  assign conf_we_o         = we_q;
  assign tile_id_o         = tile_id_q;
  assign num_tiles_o       = num_tiles_q;
  assign core_base_o       = core_base_q;
  assign domain_numcores_o = domain_numcores_q;
  assign gmem_size_o       = gmem_size_q;
  assign gmem_tile_o       = gmem_tile_q;
  assign lmem_size_o       = lmem_size_q;
  assign seed_o            = seed_q;
  assign num_cts_o         = num_cts_q;
  assign na_mpsimple_o     = mpsimple_q;
  assign na_dma_o          = dma_q;
  assign cdc_present_o     = cdc_present_q;
  assign cdc_dynamic_o     = cdc_dynamic_q;

endmodule

// File: tb/tb_networkadapter_conf_reader.sv
// Scoreboard bench: a responder model answers reads; expected accesses and cached values come from the register map.
module tb_networkadapter_conf_reader;

  typedef struct packed {
    logic [15:0] a;
    logic        we;
    logic [31:0] d;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst, start, req, ack, busy, done, en, we;
  logic [2:0]  cdata;
  logic [15:0] addr;
  logic [31:0] din, dout;
  logic [31:0] tile_id, num_tiles, core_base, dom_nc, gmem_size, gmem_tile, lmem_size, seed;
  logic [6:0]  ncts;
  logic        mps, dma, cdcp, cdcd;
  logic [5:0]  idx;
  logic [15:0] tile;

  logic        start2, busy2, done2, ack2, en2, we2;
  logic [15:0] addr2, tile2;
  logic [31:0] din2, dout2;
  logic [31:0] o2 [8];
  logic [6:0]  ncts2;
  logic [3:0]  fl2;
  logic [5:0]  idx2;

  logic [31:0] rf  [0:255];
  logic [15:0] ent [0:127];
  acc_t        exp_q [$];
  int          tests = 0;
  int          fails = 0;
  int          run2  = 0;
  int          reads2 = 0;
  logic [15:0] last2;
  int          fw [12] = '{0, 1, 3, 4, 6, 7, 8, 9, 10, 11, 64, 65};

  always #5 clk = ~clk;

  assign dout  = rf[addr[9:2]];
  assign dout2 = rf[addr2[9:2]];

  networkadapter_conf_reader dut (
    .clk(clk), .rst(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .cdc_wr_req_i(req), .cdc_wr_data_i(cdata), .cdc_wr_ack_o(ack),
    .conf_addr_o(addr), .conf_din_o(din), .conf_en_o(en), .conf_we_o(we), .conf_dout_i(dout),
    .tile_id_o(tile_id), .num_tiles_o(num_tiles), .core_base_o(core_base),
    .domain_numcores_o(dom_nc), .gmem_size_o(gmem_size), .gmem_tile_o(gmem_tile),
    .lmem_size_o(lmem_size), .seed_o(seed), .num_cts_o(ncts),
    .na_mpsimple_o(mps), .na_dma_o(dma), .cdc_present_o(cdcp), .cdc_dynamic_o(cdcd),
    .ctlist_idx_i(idx), .ctlist_tile_o(tile)
  );

  networkadapter_conf_reader #(.RD_WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .busy_o(busy2), .done_o(done2),
    .cdc_wr_req_i(1'b0), .cdc_wr_data_i(3'd0), .cdc_wr_ack_o(ack2),
    .conf_addr_o(addr2), .conf_din_o(din2), .conf_en_o(en2), .conf_we_o(we2), .conf_dout_i(dout2),
    .tile_id_o(o2[0]), .num_tiles_o(o2[1]), .core_base_o(o2[2]),
    .domain_numcores_o(o2[3]), .gmem_size_o(o2[4]), .gmem_tile_o(o2[5]),
    .lmem_size_o(o2[6]), .seed_o(o2[7]), .num_cts_o(ncts2),
    .na_mpsimple_o(fl2[0]), .na_dma_o(fl2[1]), .cdc_present_o(fl2[2]), .cdc_dynamic_o(fl2[3]),
    .ctlist_idx_i(idx2), .ctlist_tile_o(tile2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill(input int n);
    for (int w = 0; w < 256; w++) rf[w] = $urandom;
    rf[10] = n;
    for (int k = 0; k < 128; k++) ent[k] = 16'($urandom);
  endtask

  task automatic pack();
    for (int j = 0; j < 64; j++) rf[128 + j] = {ent[2*j], ent[2*j+1]};
  endtask

  task automatic push_scan(input int nc);
    for (int i = 0; i < 12; i++) exp_q.push_back('{16'(fw[i] * 4), 1'b0, 32'd0});
    for (int k = 0; k < nc; k++) exp_q.push_back('{16'(512 + 2 * k), 1'b0, 32'd0});
  endtask

  task automatic wait_ack();
    int cyc = 0;
    while (!ack && cyc < 10) begin @(posedge clk); #1; cyc++; end
    chk("ack_latency", cyc, 1);
    chk("wr_en_we", {en, we, busy}, 3'b111);
    req = 1'b0;
    @(posedge clk); #1;
    chk("ack_one_cycle", ack, 0);
    chk("idle_after_wr", {en, busy}, 2'b00);
  endtask

  task automatic run_scan(input int n, input bit cdc, input logic [2:0] cd);
    int nc, cyc;
    int ix [4];
    pack();
    nc = (n > 64) ? 64 : n;
    push_scan(nc);
    if (cdc) exp_q.push_back('{16'h0108, 1'b1, {29'd0, cd}});
    start = 1'b1;
    if (cdc) begin req = 1'b1; cdata = cd; end
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    cyc = 0;
    while (!done && cyc < 2000) begin @(posedge clk); #1; cyc++; end
    chk("scan_cycles", cyc, 12 + nc);
    chk("busy_at_done", busy, 0);
    chk("tile_id", tile_id, rf[0]);
    chk("num_tiles", num_tiles, rf[1]);
    chk("conf_flags", {mps, dma}, {rf[3][0], rf[3][1]});
    chk("core_base", core_base, rf[4]);
    chk("domain_numcores", dom_nc, rf[6]);
    chk("gmem", {gmem_size, gmem_tile}, {rf[7], rf[8]});
    chk("lmem_seed", {lmem_size, seed}, {rf[9], rf[11]});
    chk("num_cts", ncts, nc);
    chk("cdc_flags", {cdcp, cdcd}, {rf[64][0], rf[65][0]});
    ix = '{0, (nc > 0) ? nc - 1 : 0, (nc < 64) ? nc : 63, $urandom_range(0, 63)};
    for (int i = 0; i < 4; i++) begin
      idx = 6'(ix[i]);
      #1;
      chk("ctlist_tile", tile, (ix[i] < nc) ? ent[ix[i]] : 16'h0000);
    end
    if (cdc) wait_ack();
    chk("all_accesses_seen", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every enabled cycle must match the next expected access.
  initial begin
    acc_t e;
    forever begin
      @(negedge clk);
      if (!rst && en) begin
        if (exp_q.size() == 0) begin
          chk("extra_access", {16'd0, addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("acc_addr", addr, e.a);
          chk("acc_we", we, e.we);
          if (e.we) chk("acc_din", din, e.d);
        end
      end
    end
  end

  // Hold-length monitor for the RD_WAIT=2 instance.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        run2 = 0;
      end else if (en2) begin
        if (run2 > 0 && addr2 == last2) begin
          run2++;
        end else begin
          if (run2 > 0) chk("hold_len", run2, 3);
          run2 = 1;
          last2 = addr2;
          reads2++;
        end
      end else if (run2 > 0) begin
        chk("hold_len", run2, 3);
        run2 = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; req = 1'b0; cdata = 3'd0;
    idx = 6'd0; idx2 = 6'd0;
    fill(0);
    pack();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus", {addr, en, we, ack}, 19'd0);
    chk("rst_status", {busy, done}, 2'b00);
    chk("rst_cached", {tile_id, seed, 25'(ncts)}, 89'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed scan from the test plan.
    fill(3);
    rf[0] = 32'd5; rf[1] = 32'd8; rf[3] = 32'h3;
    ent[0] = 16'd2; ent[1] = 16'd5; ent[2] = 16'd7;
    run_scan(3, 1'b0, 3'd0);
    chk("plan_tile_id", tile_id, 5);
    chk("plan_na_dma", dma, 1);

    fill(0);
    run_scan(0, 1'b0, 3'd0);
    fill(70);
    run_scan(70, 1'b0, 3'd0);
    idx = 6'd63; #1;
    chk("entry63_lower_half", tile, rf[128 + 31][15:0]);

    // start and cdc request together: scan wins, write follows.
    fill($urandom_range(1, 5));
    run_scan(int'(rf[10]), 1'b1, 3'd5);

    // Standalone CDC write.
    cdata = 3'($urandom);
    exp_q.push_back('{16'h0108, 1'b1, {29'd0, cdata}});
    req = 1'b1;
    wait_ack();
    chk("wr_seen", exp_q.size(), 0);

    for (int r = 0; r < 5; r++) begin
      fill($urandom_range(0, 70));
      run_scan(int'(rf[10]), 1'(r[0]), 3'($urandom));
    end

    // Reset in the middle of a scan, then rescan.
    fill(20);
    pack();
    push_scan(20);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_bus", {addr, en, we, ack, busy, done}, 22'd0);
    chk("midrst_cached", {tile_id, num_tiles, 25'(ncts)}, 89'd0);
    idx = 6'd0; #1;
    chk("midrst_ctlist", tile, 0);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("no_access_after_rst", en, 0);
    fill($urandom_range(1, 10));
    run_scan(int'(rf[10]), 1'b0, 3'd0);

    // RD_WAIT=2 instance.
    fill(4);
    pack();
    reads2 = 0;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 2000) begin @(posedge clk); #1; cyc++; end
    chk("wait2_cycles", cyc, (12 + 4) * 3);
    @(negedge clk);
    chk("wait2_reads", reads2, 16);
    chk("wait2_num_cts", ncts2, 4);
    idx2 = 6'd3; #1;
    chk("wait2_ctlist", tile2, ent[3]);
    chk("wait2_tile_id", o2[0], rf[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
